// File: rtl/config_loader.sv
// config_loader: streams config words into a wrapping shadow bank, then commits the whole bank atomically
// to the active bank. Optional CONFIG_LOADER_CHECKSUM_EN adds a trailing XOR check word that gates the commit.
module config_loader #(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 42,
    parameter int ADDR_W    = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        io_start,
    input  logic [ADDR_W-1:0]           io_base_addr,
    input  logic [ADDR_W:0]             io_len,
    input  logic                        io_in_valid,
    output logic                        io_in_ready,
    input  logic [DATA_W-1:0]           io_in_data,
    input  logic [ADDR_W-1:0]           io_rd_addr,
    output logic [DATA_W-1:0]           io_rd_data,
    output logic                        io_busy,
    output logic                        io_done,
    output logic                        io_err,
    output logic                        io_configs_valid,
    output logic [DATA_W*NUM_WORDS-1:0] io_configs_out,
    output logic [1:0]                  io_dbg_state
);

    // Handshake: a word transfers on a rising edge where io_in_valid and io_in_ready are both high;
    // io_in_ready depends only on the FSM state, never on io_in_valid.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    localparam logic [1:0] S_CHECK  = 2'd2;
`endif
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);

    logic [1:0]                  r_state;
    logic [ADDR_W-1:0]           r_ptr;
    logic [ADDR_W:0]             r_remaining;
    logic                        r_err;
    logic                        r_cfg_valid;
    logic [DATA_W-1:0]           r_shadow [NUM_WORDS];
    logic [DATA_W*NUM_WORDS-1:0] r_active;
    logic [DATA_W-1:0]           r_rd_data;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]           r_xor;
`endif

    logic                        w_start_ok;
    logic                        w_accept;
    logic                        w_write;
    logic                        w_last;
    logic [ADDR_W-1:0]           w_ptr_next;
    logic                        w_rd_in_range;

    assign w_start_ok = (io_len != '0) && (io_len <= LEN_MAX) && ({1'b0, io_base_addr} < LEN_MAX);
`ifdef CONFIG_LOADER_CHECKSUM_EN
    assign io_in_ready = (r_state == S_LOAD) || (r_state == S_CHECK);
`else
    assign io_in_ready = (r_state == S_LOAD);
`endif
    assign w_accept      = io_in_ready && io_in_valid;
    assign w_write       = (r_state == S_LOAD) && io_in_valid;
    assign w_last        = (r_remaining == LEN_ONE);
    assign w_ptr_next    = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
    assign w_rd_in_range = ({1'b0, io_rd_addr} < LEN_MAX);

    assign io_busy          = (r_state != S_IDLE);
    assign io_done          = (r_state == S_COMMIT);
    assign io_err           = r_err;
    assign io_configs_valid = r_cfg_valid;
    assign io_configs_out   = r_active;
    assign io_rd_data       = r_rd_data;
    assign io_dbg_state     = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_err       <= 1'b0;
            r_cfg_valid <= 1'b0;
            r_active    <= '0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            r_xor       <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_start) begin
                        if (w_start_ok) begin
                            r_ptr       <= io_base_addr;
                            r_remaining <= io_len;
                            r_cfg_valid <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                            r_xor       <= '0;
`endif
                            r_state     <= S_LOAD;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (io_start) r_err <= 1'b1;
                    if (w_accept) begin
                        r_ptr       <= w_ptr_next;
                        r_remaining <= r_remaining - 1'b1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        r_xor       <= r_xor ^ io_in_data;
                        if (w_last) r_state <= S_CHECK;
`else
                        if (w_last) r_state <= S_COMMIT;
`endif
                    end
                end
`ifdef CONFIG_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (io_start) r_err <= 1'b1;
                    if (w_accept) begin
                        if (io_in_data == r_xor) begin
                            r_state <= S_COMMIT;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
`endif
                S_COMMIT: begin
                    if (io_start) r_err <= 1'b1;
                    for (int k = 0; k < NUM_WORDS; k++) begin
                        r_active[k*DATA_W +: DATA_W] <= r_shadow[k];
                    end
                    r_cfg_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The shadow bank is written only by data words in LOAD, never by the check word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_WORDS; k++) r_shadow[k] <= '0;
        end else if (w_write) begin
            r_shadow[r_ptr] <= io_in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (w_rd_in_range) begin
            r_rd_data <= r_shadow[io_rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: start-validation table, scripted corner cases and random frames,
// checked against an array model of the shadow and active banks.
module tb_config_loader;

    localparam int DW = 32;
    localparam int NW = 42;
    localparam int AW = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              io_start;
    logic [AW-1:0]     io_base_addr;
    logic [AW:0]       io_len;
    logic              io_in_valid;
    logic              io_in_ready;
    logic [DW-1:0]     io_in_data;
    logic [AW-1:0]     io_rd_addr;
    logic [DW-1:0]     io_rd_data;
    logic              io_busy;
    logic              io_done;
    logic              io_err;
    logic              io_configs_valid;
    logic [DW*NW-1:0]  io_configs_out;
    logic [1:0]        io_dbg_state;

    config_loader #(.DATA_W(DW), .NUM_WORDS(NW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .io_start(io_start), .io_base_addr(io_base_addr),
        .io_len(io_len), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_in_data(io_in_data), .io_rd_addr(io_rd_addr), .io_rd_data(io_rd_data),
        .io_busy(io_busy), .io_done(io_done), .io_err(io_err),
        .io_configs_valid(io_configs_valid), .io_configs_out(io_configs_out),
        .io_dbg_state(io_dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    logic [DW-1:0] shadow_m [NW];
    logic [DW-1:0] active_m [NW];
    bit            cfg_valid_m;

    typedef struct {
        int base;
        int len;
        bit ok;
        int gap_pct;
    } start_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_active(input string name);
        logic [DW*NW-1:0] e;
        int bad;
        bad = -1;
        for (int k = 0; k < NW; k++) e[k*DW +: DW] = active_m[k];
        n_vec++;
        if (io_configs_out !== e) begin
            n_fail++;
            for (int k = NW-1; k >= 0; k--) if (io_configs_out[k*DW +: DW] !== active_m[k]) bad = k;
            $display("FAIL %s: word %0d got %0h expected %0h", name, bad,
                     io_configs_out[bad*DW +: DW], active_m[bad]);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NW; k++) begin
            shadow_m[k] = '0;
            active_m[k] = '0;
        end
        cfg_valid_m = 1'b0;
    endtask

    // Runs one accepted frame starting at a negedge. gap_pct < 0 uses vpat as a repeating valid pattern.
    // mode: 0 random data, 1 A5000000+k, 2 k+1, 3 fixed 5,3.
    task automatic run_frame(input int base, input int len, input int gap_pct, input logic [7:0] vpat,
                             input int mode, input int bad_start_at, input bit bad_sum);
        int acc, cyc, ptr, total;
        logic [DW-1:0] x, d, rd_exp;
        bit v, exp_err, have_rd;
`ifdef CONFIG_LOADER_CHECKSUM_EN
        total = len + 1;
`else
        total = len;
`endif
        io_start = 1'b1; io_base_addr = AW'(base); io_len = (AW+1)'(len);
        @(negedge clk);
        io_start = 1'b0;
        cfg_valid_m = 1'b0;
        check("busy_after_start", io_busy, 1);
        acc = 0; cyc = 0; ptr = base; x = '0; exp_err = 0; have_rd = 0; rd_exp = '0;
        while (acc < total && cyc < 2000) begin
            check("in_ready_load", io_in_ready, 1);
            check("err_in_load", io_err, exp_err);
            check("cfg_valid_load", io_configs_valid, 0);
            check_active("active_held_load");
            if (have_rd) check("rd_old_on_write", io_rd_data, rd_exp);
            if (gap_pct < 0) v = vpat[cyc % 8];
            else v = ($urandom_range(0, 99) >= gap_pct);
            case (mode)
                1: d = 32'hA500_0000 + DW'(acc);
                2: d = DW'(acc + 1);
                3: d = (acc == 0) ? 32'd5 : 32'd3;
                default: d = $urandom;
            endcase
            if (acc >= len) d = bad_sum ? (x ^ 32'd1) : x;
            io_in_valid = v; io_in_data = d;
            io_rd_addr = AW'(ptr); rd_exp = shadow_m[ptr]; have_rd = 1;
            exp_err = (cyc == bad_start_at);
            io_start = exp_err; io_base_addr = AW'($urandom_range(0, 63)); io_len = 7'd1;
            @(negedge clk);
            io_start = 1'b0;
            if (v) begin
                if (acc < len) begin
                    shadow_m[ptr] = d;
                    x = x ^ d;
                    ptr = (ptr + 1) % NW;
                end
                acc++;
            end
            cyc++;
        end
        io_in_valid = 1'b0;
        if (acc < total) check("frame_timeout", acc, total);
        if (gap_pct == 0) check("frame_cycles", cyc, total);
        check("rd_old_last", io_rd_data, rd_exp);
`ifdef CONFIG_LOADER_CHECKSUM_EN
        if (bad_sum) begin
            check("sum_err", io_err, 1);
            check("sum_no_done", io_done, 0);
            check("sum_idle", io_busy, 0);
            check("sum_cfg_valid", io_configs_valid, 0);
            check_active("sum_active_kept");
            @(negedge clk);
            check("sum_err_clear", io_err, 0);
            check_active("sum_active_kept2");
            return;
        end
`endif
        check("commit_done", io_done, 1);
        check("commit_ready", io_in_ready, 0);
        check("commit_busy", io_busy, 1);
        check("commit_err", io_err, exp_err);
        check_active("active_before_commit");
        for (int k = 0; k < NW; k++) active_m[k] = shadow_m[k];
        cfg_valid_m = 1'b1;
        @(negedge clk);
        check("done_one_cycle", io_done, 0);
        check("idle_after_commit", io_busy, 0);
        check("cfg_valid_after", io_configs_valid, 1);
        check_active("active_after_commit");
    endtask

    task automatic readback_sweep();
        logic [DW-1:0] e;
        for (int a = 0; a < 64; a++) begin
            io_rd_addr = AW'(a);
            @(negedge clk);
            e = (a < NW) ? shadow_m[a] : '0;
            check("readback", io_rd_data, e);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, io_busy, 0);
        check({tag, "_ready"}, io_in_ready, 0);
        check({tag, "_done"}, io_done, 0);
        check({tag, "_err"}, io_err, 0);
        check({tag, "_cfg_valid"}, io_configs_valid, 0);
        check({tag, "_rd_data"}, io_rd_data, 0);
        check({tag, "_state"}, io_dbg_state, 0);
        check_active({tag, "_active"});
    endtask

    start_vec_t vecs [10];

    initial begin
        reset = 1'b0; io_start = 1'b0; io_base_addr = '0; io_len = '0;
        io_in_valid = 1'b0; io_in_data = '0; io_rd_addr = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // Full load with valid held high.
        run_frame(0, 42, 0, 8'hFF, 1, -1, 0);
        check("full_word41", io_configs_out[41*DW +: DW], 32'hA500_0029);
        check("full_word0", io_configs_out[0 +: DW], 32'hA500_0000);

        // Wrapping partial frame.
        run_frame(40, 4, 0, 8'hFF, 2, -1, 0);
        check("wrap_w40", io_configs_out[40*DW +: DW], 32'd1);
        check("wrap_w41", io_configs_out[41*DW +: DW], 32'd2);
        check("wrap_w0", io_configs_out[0 +: DW], 32'd3);
        check("wrap_w1", io_configs_out[1*DW +: DW], 32'd4);
        check("wrap_w2", io_configs_out[2*DW +: DW], 32'hA500_0002);
        check("wrap_w39", io_configs_out[39*DW +: DW], 32'hA500_0027);

        // Valid pattern 1,0,0,1,0,1 and a start during the frame.
        run_frame(10, 3, -1, 8'b0010_1001, 0, -1, 0);
        run_frame(20, 6, 30, 8'hFF, 0, 2, 0);
        readback_sweep();

        vecs[0] = '{base: 0,  len: 0,   ok: 0, gap_pct: 0};
        vecs[1] = '{base: 0,  len: 43,  ok: 0, gap_pct: 0};
        vecs[2] = '{base: 42, len: 1,   ok: 0, gap_pct: 0};
        vecs[3] = '{base: 63, len: 5,   ok: 0, gap_pct: 0};
        vecs[4] = '{base: 0,  len: 127, ok: 0, gap_pct: 0};
        vecs[5] = '{base: 41, len: 1,   ok: 1, gap_pct: 0};
        vecs[6] = '{base: 5,  len: 42,  ok: 1, gap_pct: 40};
        vecs[7] = '{base: 41, len: 42,  ok: 0, gap_pct: 0};
        vecs[8] = '{base: 41, len: 2,   ok: 1, gap_pct: 20};
        vecs[9] = '{base: 7,  len: 64,  ok: 0, gap_pct: 0};
        vecs[7].len = 43;
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].ok) begin
                run_frame(vecs[i].base, vecs[i].len, vecs[i].gap_pct, 8'hFF, 0, -1, 0);
            end else begin
                io_start = 1'b1; io_base_addr = AW'(vecs[i].base); io_len = (AW+1)'(vecs[i].len);
                io_in_valid = 1'b1;
                @(negedge clk);
                io_start = 1'b0; io_in_valid = 1'b0;
                check("reject_err", io_err, 1);
                check("reject_busy", io_busy, 0);
                check("reject_ready", io_in_ready, 0);
                check("reject_cfg_valid", io_configs_valid, cfg_valid_m);
                @(negedge clk);
                check("reject_err_one_cycle", io_err, 0);
                check("reject_state", io_dbg_state, 0);
                check_active("reject_active");
            end
        end

        // Reset mid-frame, asserted between clock edges.
        io_start = 1'b1; io_base_addr = '0; io_len = 7'd10;
        @(negedge clk);
        io_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            io_in_valid = 1'b1; io_in_data = $urandom;
            @(negedge clk);
        end
        io_in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_clear();
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_frame(3, 10, 25, 8'hFF, 0, -1, 0);
        readback_sweep();

`ifdef CONFIG_LOADER_CHECKSUM_EN
        run_frame(0, 2, 0, 8'hFF, 3, -1, 0);
        check("sum_w0", io_configs_out[0 +: DW], 32'd5);
        check("sum_w1", io_configs_out[1*DW +: DW], 32'd3);
        run_frame(0, 2, 0, 8'hFF, 3, -1, 1);
        run_frame(30, 20, 30, 8'hFF, 0, -1, 1);
`endif

        for (int i = 0; i < 8; i++) begin
            run_frame($urandom_range(0, NW-1), $urandom_range(1, NW), $urandom_range(0, 60), 8'hFF, 0,
                      (i % 2 == 0) ? $urandom_range(0, 5) : -1, 0);
        end
        readback_sweep();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
Parametrised, clocked successor to the level-sensitive config latch bank. Streams configuration words over a valid/ready interface into a shadow register bank with an auto-incrementing, wrapping write pointer. On frame completion, atomically commits the whole shadow bank to the active bank that drives the fabric configuration bits. Sits between the config bus deserialiser and the lut_tile config inputs; also provides registered readback of the shadow bank.

Parameters:
DATA_W, 32, width of one config word
NUM_WORDS, 42, number of config words; total config bits = DATA_W*NUM_WORDS
ADDR_W, 6, pointer/length width; must satisfy 2^ADDR_W >= NUM_WORDS

Ports:
clk  in  1  sole clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
io_start  in  1  single-cycle pulse; begins a frame
io_base_addr  in  ADDR_W  first word address of the frame; sampled on io_start
io_len  in  ADDR_W+1  number of words in the frame, 1..NUM_WORDS; sampled on io_start
io_in_valid  in  1  word available
io_in_ready  out  1  loader accepts a word
io_in_data  in  DATA_W  config word
io_rd_addr  in  ADDR_W  shadow readback address
io_rd_data  out  DATA_W  shadow word at io_rd_addr, registered
io_busy  out  1  frame in progress
io_done  out  1  one-cycle pulse on commit
io_err  out  1  one-cycle pulse on a rejected start or a checksum failure
io_configs_valid  out  1  active bank holds a committed frame
io_configs_out  out  DATA_W*NUM_WORDS  active bank; word k occupies bits [k*DATA_W +: DATA_W]

Behaviour:
- Reset (reset=0, asynchronous): shadow bank, active bank, io_rd_data, pointer and count = 0; state IDLE; io_in_ready, io_busy, io_done, io_err, io_configs_valid = 0.
- FSM states: IDLE, LOAD, (CHECK when the optional feature is enabled), COMMIT.
- IDLE, io_start with 1 <= io_len <= NUM_WORDS and io_base_addr < NUM_WORDS: ptr <= io_base_addr, remaining <= io_len, io_configs_valid <= 0, go to LOAD.
- IDLE, io_start with io_len = 0, io_len > NUM_WORDS, or base out of range: io_err pulses the next cycle; state stays IDLE; no other state changes.
- LOAD: io_in_ready = 1 and io_busy = 1. A word is accepted when io_in_valid & io_in_ready. On accept: shadow[ptr] <= io_in_data; ptr <= (ptr == NUM_WORDS-1) ? 0 : ptr+1; remaining decrements.
- LOAD, accept with remaining = 1: go to COMMIT (or CHECK if the feature is enabled).
- COMMIT, one cycle: active bank <= entire shadow bank including the final word; io_configs_valid <= 1; io_done pulses in this cycle; then IDLE. Throughput: a frame of N words takes N accept cycles + 1 commit cycle.
- io_start during LOAD/CHECK/COMMIT: ignored, io_err pulses. The frame continues unaffected.
- io_in_ready = 0 in IDLE and COMMIT. io_in_valid in those states is ignored.
- io_configs_out changes only in COMMIT. It never shows partial frames; it holds its old value throughout LOAD.
- Readback: io_rd_data <= shadow[io_rd_addr] each cycle, 1-cycle latency. An out-of-range address returns 0. A same-cycle write to that address returns the old value.
- Reset asserted mid-frame: everything clears immediately, including the active bank.

Optional Feature:
CONFIG_LOADER_CHECKSUM_EN
- Defined: after the last data word, LOAD moves to CHECK, which accepts one extra word (same handshake). Pass if that word equals the XOR of all frame data words, then go to COMMIT. Fail: io_err pulses, the active bank is untouched, io_configs_valid stays 0, return to IDLE. The shadow bank keeps the written data.
- Undefined: no CHECK state; the last data word goes straight to COMMIT.

Test Plan:
- Full load: reset, start base=0 len=42, words k -> 32'hA5000000+k with valid held high -> io_done pulses on cycle 43 after the first accept; io_configs_out word 41 = 32'hA5000029; io_configs_valid = 1.
- Wrap and partial: after the full load, start base=40 len=4, words 1,2,3,4 -> shadow/active words 40,41,0,1 = 1,2,3,4; words 2..39 unchanged.
- Backpressure/gaps: len=3 with io_in_valid toggling 1,0,0,1,0,1 -> exactly 3 words written; io_configs_out unchanged until the COMMIT cycle.
- Errors: start len=0 -> io_err for 1 cycle, state IDLE. Start during LOAD -> io_err, frame completes normally.
- Reset mid-frame: reset=0 after 5 of 10 words -> all outputs 0 asynchronously. A subsequent clean frame loads correctly.
- Checksum (macro on): len=2, words 5,3, check word 6 -> commit. Check word 7 -> io_err, active bank unchanged, io_configs_valid = 0.
